// File: rtl/scc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : scc_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer for the SCC core. It walks
//             IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
//             From the opcode Instruction[31:25] it generates the IR load,
//             PC update, register-file/flag write and data-memory strobes.
//             It also handles HALT and data-memory timeout faults.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, rising edge
//    rst         in   synchronous active-high reset
//    run         in   start request, leaves IDLE
//    instr_op    in   [6:0] opcode, latched in DECODE
//    cond_true   in   B.cond condition, used combinationally in EXEC
//    dmem_ready  in   data memory completes current access
//    ir_load     out  load instruction register (FETCH)
//    pc_en       out  update PC this cycle
//    pc_sel      out  0 = PC+1, 1 = branch target
//    rf_we       out  register-file write enable (WB)
//    flags_we    out  NZCV flag write enable (WB)
//    dmem_re     out  data-memory read strobe, held through MEM
//    dmem_we     out  data-memory write strobe, held through MEM
//    halted      out  core stopped in HALT
//    mem_err     out  sticky data-memory timeout fault
//    state       out  [2:0] current state, debug
//    retired_cnt out  [31:0] retired-instruction counter (optional)
//    stall_cnt   out  [31:0] MEM-stall cycle counter (optional)
//  Build option
//    SCC_PERF_CNT_EN : when defined, adds retired_cnt / stall_cnt
// ============================================================================
module scc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] instr_op,
  input  logic       cond_true,
  input  logic       dmem_ready,
  output logic       ir_load,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       rf_we,
  output logic       flags_we,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       halted,
  output logic       mem_err,
  output logic [2:0] state
`ifdef SCC_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Instruction classes resolved in EXEC
  localparam logic [2:0] CLS_WB   = 3'd0;  // data op, write back
  localparam logic [2:0] CLS_MEM  = 3'd1;  // load / store
  localparam logic [2:0] CLS_JMP  = 3'd2;  // B / BR, always taken
  localparam logic [2:0] CLS_BCND = 3'd3;  // B.cond
  localparam logic [2:0] CLS_NOP  = 3'd4;  // NOP or undefined encoding
  localparam logic [2:0] CLS_HALT = 3'd5;  // HALT instruction

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  // ALU sub-op field op[2:0] is valid for 001..101
  function automatic logic alu_ok(input logic [6:0] op);
    return (op[2:0] != 3'b000) && (op[2:0] <= 3'd5);
  endfunction

  function automatic logic [2:0] classify(input logic [6:0] op);
    logic [2:0] cls;
    cls = CLS_NOP;
    case (op[6:5])
      2'b00, 2'b01: begin
        if (((op[6:5] == 2'b00) && (op[4:0] <= 5'd5)) ||
            (op[4] && alu_ok(op)) ||
            ((op[6:5] == 2'b01) && (op[4:0] == 5'b10110))) begin
          cls = CLS_WB;
        end
      end
      2'b10: cls = CLS_MEM;
      default: begin
        // Branches occupy the op[4]=0 half of the fl=11 space, so the HALT
        // opcode 1110000 (op[4]=1) does not alias to B.
        if (!op[4] && (op[3:0] == 4'b0000))      cls = CLS_JMP;
        else if (!op[4] && (op[3:0] == 4'b0001)) cls = CLS_BCND;
        else if (!op[4] && (op[3:0] == 4'b0010)) cls = CLS_JMP;
        else if (op[2])                          cls = CLS_NOP;
        else if (op[4] || op[3])                 cls = CLS_HALT;
        else                                     cls = CLS_NOP;
      end
    endcase
    return cls;
  endfunction

  state_t          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_err_d;

  logic ir_load_q, ir_load_d;
  logic pc_en_q, pc_en_d;
  logic pc_sel_q, pc_sel_d;
  logic bcnd_q, bcnd_d;
  logic rf_we_q, rf_we_d;
  logic flags_we_q, flags_we_d;
  logic dmem_re_q, dmem_re_d;
  logic dmem_we_q, dmem_we_d;
  logic halted_q, halted_d;
  logic mem_err_q;

  logic [2:0] cls_d;

  // Next state plus next-cycle output values. Outputs are registered, so
  // they are decoded from the state being entered and the latched opcode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;

    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = instr_op;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (classify(op_q))
          CLS_WB:   state_d = ST_WB;
          CLS_MEM: begin
            state_d = ST_MEM;
            cnt_d   = '0;
          end
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_d = ST_WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (cnt_q + TO_W'(1) == TO_LIMIT) begin
            state_d   = ST_HALT;
            mem_err_d = 1'b1;
          end
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;  // illegal code 7
    endcase

    cls_d      = classify(op_d);
    ir_load_d  = 1'b0;
    pc_en_d    = 1'b0;
    pc_sel_d   = 1'b0;
    bcnd_d     = 1'b0;
    rf_we_d    = 1'b0;
    flags_we_d = 1'b0;
    dmem_re_d  = 1'b0;
    dmem_we_d  = 1'b0;
    halted_d   = 1'b0;

    case (state_d)
      ST_FETCH: ir_load_d = 1'b1;
      ST_EXEC: begin
        case (cls_d)
          CLS_JMP: begin
            pc_en_d  = 1'b1;
            pc_sel_d = 1'b1;
          end
          CLS_BCND: begin
            pc_en_d = 1'b1;
            bcnd_d  = 1'b1;
          end
          CLS_NOP: pc_en_d = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_re_d = op_d[0];
        dmem_we_d = ~op_d[0];
      end
      ST_WB: begin
        pc_en_d    = 1'b1;
        rf_we_d    = ~((op_d[6:5] == 2'b10) && !op_d[0]);
        flags_we_d = (op_d[6:5] != 2'b10) && (op_d[4:3] == 2'b11) && alu_ok(op_d);
      end
      ST_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      mem_err_q  <= 1'b0;
      ir_load_q  <= 1'b0;
      pc_en_q    <= 1'b0;
      pc_sel_q   <= 1'b0;
      bcnd_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      flags_we_q <= 1'b0;
      dmem_re_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      mem_err_q  <= mem_err_d;
      ir_load_q  <= ir_load_d;
      pc_en_q    <= pc_en_d;
      pc_sel_q   <= pc_sel_d;
      bcnd_q     <= bcnd_d;
      rf_we_q    <= rf_we_d;
      flags_we_q <= flags_we_d;
      dmem_re_q  <= dmem_re_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
    end
  end

  assign ir_load  = ir_load_q;
  assign pc_en    = pc_en_q;
  // cond_true is only valid during EXEC, so B.cond selects it live
  assign pc_sel   = pc_sel_q | (bcnd_q & cond_true);
  assign rf_we    = rf_we_q;
  assign flags_we = flags_we_q;
  assign dmem_re  = dmem_re_q;
  assign dmem_we  = dmem_we_q;
  assign halted   = halted_q;
  assign mem_err  = mem_err_q;
  assign state    = state_q;

`ifdef SCC_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      // A HALT instruction retires without a PC update
      if (pc_en_q || ((state_q == ST_EXEC) && (state_d == ST_HALT))) begin
        retired_q <= retired_q + 32'd1;
      end
      if ((state_q == ST_MEM) && !dmem_ready) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule
`default_nettype wire
